// File: rtl/color_pkg.sv
// rtl/color_pkg.sv - shared widths, mode encoding and reset code for the colour sequencer
package color_pkg;
  localparam int CODE_W = 3;
  localparam logic [CODE_W-1:0] CODE_RESET = 3'b000;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_AUTO   = 1'b1
  } mode_e;
endpackage

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - 2-flop synchronizer, consecutive-sample debounce and registered rise pulse
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          level_dly_q;
  logic          press_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any cycle where the input agrees with the accepted level restarts qualification.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      press_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= btn_i;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      press_q     <= level_q & ~level_dly_q;
      cnt_q       <= cnt_d;
    end
  end

  assign press_o = press_q;
endmodule

// File: rtl/color_code_sequencer.sv
// rtl/color_code_sequencer.sv - MANUAL/AUTO mode FSM, auto-step prescaler and registered 3-bit colour code
module color_code_sequencer
  import color_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int AUTO_PERIOD     = 50000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_next,
  input  logic              btn_mode,
  output logic [CODE_W-1:0] code,
  output logic              code_strobe,
  output logic              auto_mode
);
  localparam int PW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(AUTO_PERIOD - 1);

  logic              next_ev, mode_ev;
  logic              tc, inc;
  mode_e             mode_q, mode_d;
  logic [PW-1:0]     pre_q, pre_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              strobe_q, strobe_d;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next_db (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (btn_next),
    .press_o(next_ev)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (btn_mode),
    .press_o(mode_ev)
  );

  // A next press and a terminal count landing together merge into one step.
  always_comb begin
    tc       = (mode_q == MODE_AUTO) && (pre_q == PRE_LAST);
    inc      = next_ev | tc;
    code_d   = code_q + CODE_W'(inc);
    strobe_d = inc;
    mode_d   = mode_q;
    pre_d    = '0;
    if (mode_ev) begin
      mode_d = (mode_q == MODE_AUTO) ? MODE_MANUAL : MODE_AUTO;
    end else if ((mode_q == MODE_AUTO) && !inc) begin
      pre_d = pre_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q   <= MODE_MANUAL;
      pre_q    <= '0;
      code_q   <= CODE_RESET;
      strobe_q <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      pre_q    <= pre_d;
      code_q   <= code_d;
      strobe_q <= strobe_d;
    end
  end

  assign code        = code_q;
  assign code_strobe = strobe_q;
  assign auto_mode   = (mode_q == MODE_AUTO);
endmodule

// File: tb/tb_color_code_sequencer.sv
// tb/tb_color_code_sequencer.sv - vector table, directed corner sequences and random run against a window-based model
module tb_color_code_sequencer;
  localparam int DB = 4;
  localparam int AP = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_next;
  logic       btn_mode;
  logic [2:0] code;
  logic       code_strobe;
  logic       auto_mode;

  color_code_sequencer #(.DEBOUNCE_CYCLES(DB), .AUTO_PERIOD(AP)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_next   (btn_next),
    .btn_mode   (btn_mode),
    .code       (code),
    .code_strobe(code_strobe),
    .auto_mode  (auto_mode)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pat;
    int          len;
    int          exp_strobes;
  } vec_t;

  vec_t vecs[6];

  int tests = 0;
  int fails = 0;

  // Model: a level flips once the last DB raw samples (seen two edges late) all disagree with it.
  int       edge_no = 0;
  int       anchor  = 0;
  int       m_code  = 0;
  bit       m_auto  = 0;
  bit       m_strobe = 0;
  bit [5:0] hn = '0, hm = '0;
  bit       lvl_n = 0, lvl_m = 0;
  bit [1:0] rn = '0, rm = '0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_no);
    end
  endtask

  function automatic void deb(input bit raw, inout bit [5:0] h, inout bit lvl, output bit rise);
    h = {h[4:0], raw};
    rise = 1'b0;
    if (h[5:2] == {4{~lvl}}) begin
      lvl  = ~lvl;
      rise = lvl;
    end
  endfunction

  task automatic model_step();
    bit nev, mev, step, inc, rise_n, rise_m;
    if (rst) begin
      hn = '0; hm = '0; lvl_n = 0; lvl_m = 0; rn = '0; rm = '0;
      m_code = 0; m_auto = 0; m_strobe = 0; anchor = edge_no;
    end else begin
      nev  = rn[1];
      mev  = rm[1];
      step = m_auto && (edge_no - anchor == AP);
      inc  = nev | step;
      m_code   = (m_code + int'(inc)) % 8;
      m_strobe = inc;
      if (mev) begin
        m_auto = !m_auto;
        anchor = edge_no;
      end else if (inc) begin
        anchor = edge_no;
      end
      deb(btn_next, hn, lvl_n, rise_n);
      deb(btn_mode, hm, lvl_m, rise_m);
      rn = {rn[0], rise_n};
      rm = {rm[0], rise_m};
    end
    edge_no++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("model_code", int'(code), m_code);
    chk("model_strobe", int'(code_strobe), int'(m_strobe));
    chk("model_auto", int'(auto_mode), int'(m_auto));
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    btn_next = 1'b0;
    btn_mode = 1'b0;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  initial begin
    int cnt, first, hold_n, hold_m;
    int st_ticks[$];
    int st_codes[$];

    vecs[0] = '{32'h0000_01C7,  9, 0};
    vecs[1] = '{32'h000F_FFFF, 20, 1};
    vecs[2] = '{32'h0000_000F,  4, 1};
    vecs[3] = '{32'h0000_0007,  3, 0};
    vecs[4] = '{32'h0003_F03F, 18, 2};
    vecs[5] = '{32'h0000_7E3F, 15, 1};

    rst = 1'b1;
    btn_next = 1'b0;
    btn_mode = 1'b0;

    do_reset(3);
    for (int t = 0; t < 20; t++) begin
      tick();
      chk("reset_code", int'(code), 0);
      chk("reset_strobe", int'(code_strobe), 0);
      chk("reset_auto", int'(auto_mode), 0);
    end

    for (int i = 0; i < 6; i++) begin
      logic [31:0] p;
      p = vecs[i].pat;
      do_reset(2);
      cnt = 0;
      for (int t = 0; t < vecs[i].len + 15; t++) begin
        btn_next = (t < vecs[i].len) ? p[t] : 1'b0;
        tick();
        cnt += int'(code_strobe);
      end
      chk($sformatf("vec%0d_strobes", i), cnt, vecs[i].exp_strobes);
      chk($sformatf("vec%0d_code", i), int'(code), vecs[i].exp_strobes % 8);
    end

    do_reset(2);
    repeat (7) begin
      btn_next = 1'b1; repeat (6) tick();
      btn_next = 1'b0; repeat (6) tick();
    end
    chk("wrap_pre_code", int'(code), 7);
    cnt = 0;
    first = -1;
    for (int t = 1; t <= 30; t++) begin
      btn_next = (t <= 20);
      tick();
      if (code_strobe) begin
        cnt++;
        if (first < 0) first = t;
      end
    end
    chk("wrap_latency", first, 8);
    chk("wrap_strobes", cnt, 1);
    chk("wrap_code", int'(code), 0);

    do_reset(2);
    for (int t = 1; t <= 64; t++) begin
      btn_mode = (t <= 6);
      btn_next = (t >= 31 && t <= 36);
      tick();
      if (code_strobe) begin
        st_ticks.push_back(t);
        st_codes.push_back(int'(code));
      end
    end
    chk("auto_strobe_count", st_ticks.size(), 5);
    for (int i = 0; i < st_ticks.size() && i < 5; i++) begin
      chk($sformatf("auto_step%0d_tick", i), st_ticks[i], 18 + 10 * i);
      chk($sformatf("auto_step%0d_code", i), st_codes[i], i + 1);
    end
    chk("auto_mode_on", int'(auto_mode), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cnt = 0;
    for (int t = 0; t < 25; t++) begin
      tick();
      cnt += int'(code_strobe);
    end
    chk("midperiod_rst_strobes", cnt, 0);
    chk("midperiod_rst_code", int'(code), 0);
    chk("midperiod_rst_auto", int'(auto_mode), 0);

    do_reset(2);
    hold_n = 0;
    hold_m = 0;
    for (int t = 0; t < 3000; t++) begin
      if (hold_n == 0) begin
        btn_next = 1'($urandom_range(0, 1));
        hold_n = $urandom_range(1, 10);
      end
      if (hold_m == 0) begin
        btn_mode = 1'($urandom_range(0, 1));
        hold_m = $urandom_range(1, 12);
      end
      hold_n--;
      hold_m--;
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/color_code_sequencer.md
COLOR_CODE_SEQUENCER -- requirements
Module: color_code_sequencer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000, number of consecutive stable synchronized samples before a button level is accepted.
REQ-002 Parameter AUTO_PERIOD, default 50000000, clock cycles between automatic code steps in AUTO mode.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 btn_next  input  1  raw, asynchronous, active-high push button; each accepted press advances the code.
REQ-006 btn_mode  input  1  raw, asynchronous, active-high push button; each accepted press toggles MANUAL/AUTO.
REQ-007 code  output  3  registered colour code {A,B,C} = {code[2],code[1],code[0]} driving the downstream RGB decoder.
REQ-008 code_strobe  output  1  one-cycle pulse in the cycle code takes a new value.
REQ-009 auto_mode  output  1  1 while in AUTO state, 0 in MANUAL.

Function
REQ-010 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-011 Debounced level SHALL change only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch-free cycle (input equal to level) SHALL clear the counter.
REQ-012 A press event SHALL be a single-cycle pulse on the 0->1 transition of the debounced level; release generates no event.
REQ-013 Latency raw press -> press event SHALL be 2 (sync) + DEBOUNCE_CYCLES + 1 cycles, stable input assumed.
REQ-014 FSM states: MANUAL (reset state), AUTO; mode press event toggles state in the following cycle.
REQ-015 MANUAL: next press event SHALL increment code by 1 modulo 8 (7 -> 0) one cycle after the event.
REQ-016 AUTO: prescaler counts 0..AUTO_PERIOD-1; on terminal count code SHALL increment modulo 8 and prescaler wraps to 0.
REQ-017 AUTO: next press event SHALL increment code immediately and clear the prescaler; simultaneous terminal count and next event SHALL produce exactly one increment.
REQ-018 Prescaler SHALL be cleared on every MANUAL->AUTO and AUTO->MANUAL transition; it SHALL not count in MANUAL.
REQ-019 Simultaneous mode and next events SHALL apply the increment and the mode toggle in the same cycle.
REQ-020 code_strobe SHALL assert exactly in the cycle code updates, never otherwise.
REQ-021 Prescaler width SHALL be $clog2(AUTO_PERIOD); debounce counter width $clog2(DEBOUNCE_CYCLES+1); no overflow beyond terminal values.

Reset
REQ-022 rst SHALL, on the clock edge it is sampled high, set code=3'b000, code_strobe=0, auto_mode=0, state=MANUAL, prescaler=0, debounce counters=0, debounced levels=0, synchronizer flops=0.
REQ-023 rst asserted mid-debounce or mid-period SHALL discard partial counts; no event or strobe SHALL be emitted in the cycle following reset release.
REQ-024 A button held through reset release SHALL register one press only after full DEBOUNCE_CYCLES qualification.

Structure
REQ-025 Shared package color_pkg SHALL hold CODE_W=3, the mode enum {MODE_MANUAL, MODE_AUTO}, and the reset code constant CODE_RESET=3'b000.
REQ-026 One sub-module button_debouncer (synchronizer + debounce counter + rise detector, parameter DEBOUNCE_CYCLES) SHALL be instantiated twice.
REQ-027 Top level holds only FSM, prescaler and code register; all outputs registered.

Verification (DEBOUNCE_CYCLES=4, AUTO_PERIOD=10)
REQ-028 rst high 3 cycles, then low -> code=0, auto_mode=0, code_strobe=0 for 20 idle cycles.
REQ-029 btn_next high 20 cycles from code=7 in MANUAL -> exactly one strobe, code=0, 8 cycles after rising input (REQ-013 + 1).
REQ-030 btn_next glitch high 3 cycles, low 3, high 3 -> no strobe, code unchanged.
REQ-031 mode press then idle 35 cycles -> auto_mode=1, code steps 0->1->2->3 at 10-cycle spacing, one strobe each.
REQ-032 In AUTO, next event coincident with terminal count -> code advances by exactly 1, next auto step 10 cycles later.
REQ-033 rst asserted at prescaler=6 in AUTO -> code=0, MANUAL, no further auto steps.
